ct_f_spsram_4096x144_ctrl: RTL and testbench

//  Upstream access controller for the 4096x144 FPGA single-port SRAM model.

---
 rtl/ct_f_spsram_4096x144_ctrl_if.sv | 32 +++
 rtl/ct_f_spsram_4096x144_ctrl.sv | 150 +++++++++++++++
 tb/tb_ct_f_spsram_4096x144_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ct_f_spsram_4096x144_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ct_f_spsram_4096x144_ctrl_if
// Brief    : Request/response bus between upstream logic and the SRAM controller.
// Revision : 1.0
// ============================================================================
interface ct_f_spsram_4096x144_ctrl_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 144
);
  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_wmask;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  init_done;

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata, init_done
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata, init_done
  );
endinterface
`default_nettype wire

// File: rtl/ct_f_spsram_4096x144_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ct_f_spsram_4096x144_ctrl
// Brief    : Valid/ready access controller for the 4096x144 single-port SRAM,
//            with read response FIFO. Macro CT_F_SPSRAM_INIT_CLR_EN adds a
//            zero-clear sweep of the array after reset.
// Revision : 1.0
// ============================================================================
module ct_f_spsram_4096x144_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 144,
  parameter int RSP_DEPTH  = 2
) (
  input  wire logic                  forever_cpuclk,
  input  wire logic                  cpurst_b,
  ct_f_spsram_4096x144_ctrl_if.slave bus,
  output logic      [ADDR_WIDTH-1:0] sram_a,
  output logic                       sram_cen,
  output logic                       sram_gwen,
  output logic      [DATA_WIDTH-1:0] sram_wen,
  output logic      [DATA_WIDTH-1:0] sram_d,
  input  wire logic [DATA_WIDTH-1:0] sram_q
);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_clr_active;
  logic                  w_clr_last;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_accept;
  logic                  w_req_rdy;
  logic                  w_init_done;
  logic                  w_pop;
  logic [CNT_W-1:0]      w_used;

  logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_rd_pend;

`ifdef CT_F_SPSRAM_INIT_CLR_EN
  logic [ADDR_WIDTH-1:0] r_clr_addr;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_clr_addr <= '0;
    end else if (r_state == ST_INIT) begin
      r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
    end
  end

  assign w_clr_active = 1'b1;
  assign w_clr_last   = &r_clr_addr;
  assign w_clr_addr   = r_clr_addr;
`else
  assign w_clr_active = 1'b0;
  assign w_clr_last   = 1'b1;
  assign w_clr_addr   = '0;
`endif

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A pop in the same cycle frees a credit, so a full FIFO being drained
  // still admits a new read and reads stream at one per cycle.
  assign w_pop  = (r_cnt != '0) & bus.rsp_rdy;
  assign w_used = r_cnt + CNT_W'(r_rd_pend) - CNT_W'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_init_done = 1'b0;
    w_req_rdy   = 1'b0;
    w_accept    = 1'b0;
    sram_a      = bus.req_addr;
    sram_d      = bus.req_wdata;
    sram_cen    = 1'b1;
    sram_gwen   = 1'b1;
    sram_wen    = '1;
    case (r_state)
      ST_INIT: begin
        // Reset also holds r_state in INIT, so gate the sweep to keep pins idle.
        if (w_clr_active && cpurst_b) begin
          sram_a    = w_clr_addr;
          sram_d    = '0;
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_wen  = '0;
        end
        if (w_clr_last) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_init_done = 1'b1;
        w_req_rdy   = (w_used < CNT_W'(RSP_DEPTH));
        w_accept    = bus.req_vld & w_req_rdy;
        if (w_accept) begin
          sram_cen = 1'b0;
          if (bus.req_wr) begin
            sram_gwen = 1'b0;
            sram_wen  = ~bus.req_wmask;
          end
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= w_accept & ~bus.req_wr;
      if (r_rd_pend) begin
        r_mem[r_wptr] <= sram_q;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_cnt <= r_cnt + CNT_W'(r_rd_pend) - CNT_W'(w_pop);
    end
  end

  assign bus.req_rdy   = w_req_rdy;
  assign bus.init_done = w_init_done;
  assign bus.rsp_vld   = (r_cnt != '0);
  assign bus.rsp_rdata = r_mem[r_rptr];

endmodule
`default_nettype wire

// File: tb/tb_ct_f_spsram_4096x144_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ct_f_spsram_4096x144_ctrl
// Brief    : Directed bench with an SRAM model and a reference model of the
//            controller's externally visible behaviour.
// Revision : 1.0
// ============================================================================
module tb_ct_f_spsram_4096x144_ctrl;
`ifdef CT_F_SPSRAM_INIT_CLR_EN
  localparam int INIT_CYC = 4096;
`else
  localparam int INIT_CYC = 1;
`endif
  localparam logic [143:0] ONES = '1;

  logic          clk;
  logic          cpurst_b;
  logic [11:0]   sram_a;
  logic          sram_cen;
  logic          sram_gwen;
  logic [143:0]  sram_wen;
  logic [143:0]  sram_d;
  logic [143:0]  sram_q;

  int checks = 0;
  int errors = 0;

  ct_f_spsram_4096x144_ctrl_if #(.ADDR_WIDTH(12), .DATA_WIDTH(144)) bus ();

  ct_f_spsram_4096x144_ctrl #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(144),
    .RSP_DEPTH (2)
  ) u_dut (
    .forever_cpuclk(clk),
    .cpurst_b      (cpurst_b),
    .bus           (bus),
    .sram_a        (sram_a),
    .sram_cen      (sram_cen),
    .sram_gwen     (sram_gwen),
    .sram_wen      (sram_wen),
    .sram_d        (sram_d),
    .sram_q        (sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: per-bit masked write, registered read output.
  logic [143:0] sram_mem [4096];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= sram_mem[sram_a];
    end
  end

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [143:0] pattern(input int i);
    logic [15:0] w;
    w = 16'(i) ^ 16'hA5C3;
    return {9{w}};
  endfunction

  // Reference model: expected array contents plus outstanding reads in order.
  typedef struct {
    logic [143:0] data;
    int           rdy_cyc;
  } exp_t;

  logic [143:0] exp_mem [4096];
  exp_t         q[$];
  int           cyc = 0;
  bit           cleared = 1'b0;

  always @(negedge clk) begin
    bit exp_done, exp_vld, pop, exp_rdy, acc;
    if (!cpurst_b) begin
      q.delete();
      cyc = 0;
`ifdef CT_F_SPSRAM_INIT_CLR_EN
      if (!cleared) for (int i = 0; i < 4096; i++) exp_mem[i] = '0;
`endif
      cleared = 1'b1;
      chk("rst_rsp_vld",   144'(bus.rsp_vld),   144'(0));
      chk("rst_rsp_rdata", bus.rsp_rdata,       144'(0));
      chk("rst_req_rdy",   144'(bus.req_rdy),   144'(0));
      chk("rst_init_done", 144'(bus.init_done), 144'(0));
      chk("rst_cen",       144'(sram_cen),      144'(1));
      chk("rst_gwen",      144'(sram_gwen),     144'(1));
      chk("rst_wen",       sram_wen,            ONES);
    end else begin
      cleared  = 1'b0;
      exp_done = (cyc >= INIT_CYC);
      exp_vld  = (q.size() > 0) && (q[0].rdy_cyc <= cyc);
      pop      = exp_vld && bus.rsp_rdy;
      exp_rdy  = exp_done && ((q.size() - int'(pop)) < 2);
      acc      = exp_rdy && bus.req_vld;
      chk("init_done", 144'(bus.init_done), 144'(exp_done));
      chk("req_rdy",   144'(bus.req_rdy),   144'(exp_rdy));
      chk("rsp_vld",   144'(bus.rsp_vld),   144'(exp_vld));
      if (exp_vld) chk("rsp_rdata", bus.rsp_rdata, q[0].data);
      if (exp_done) begin
        chk("sram_cen",  144'(sram_cen),  144'(!acc));
        chk("sram_gwen", 144'(sram_gwen), 144'(!(acc && bus.req_wr)));
        if (acc) chk("sram_a", 144'(sram_a), 144'(bus.req_addr));
        if (acc && bus.req_wr) begin
          chk("sram_wen", sram_wen, ~bus.req_wmask);
          chk("sram_d",   sram_d,   bus.req_wdata);
        end else begin
          chk("sram_wen_idle", sram_wen, ONES);
        end
      end else begin
`ifdef CT_F_SPSRAM_INIT_CLR_EN
        chk("clr_cen",  144'(sram_cen),  144'(0));
        chk("clr_gwen", 144'(sram_gwen), 144'(0));
        chk("clr_a",    144'(sram_a),    144'(cyc));
        chk("clr_wen",  sram_wen,        144'(0));
        chk("clr_d",    sram_d,          144'(0));
`else
        chk("pre_run_cen", 144'(sram_cen), 144'(1));
`endif
      end
      if (pop) void'(q.pop_front());
      if (acc && bus.req_wr)
        exp_mem[bus.req_addr] = (exp_mem[bus.req_addr] & ~bus.req_wmask) | (bus.req_wdata & bus.req_wmask);
      if (acc && !bus.req_wr) q.push_back('{data: exp_mem[bus.req_addr], rdy_cyc: cyc + 2});
      cyc++;
    end
  end

  task automatic wr(input logic [11:0] a, input logic [143:0] d, input logic [143:0] m);
    int c = 0;
    bus.req_vld = 1'b1; bus.req_wr = 1'b1;
    bus.req_addr = a; bus.req_wdata = d; bus.req_wmask = m;
    @(negedge clk);
    while (!bus.req_rdy && c < 20) begin
      @(posedge clk); #1; c++;
      @(negedge clk);
    end
    chk("wr_accept_bound", 144'(c < 20), 144'(1));
    @(posedge clk); #1;
    bus.req_vld = 1'b0; bus.req_wr = 1'b0;
  endtask

  task automatic run_reads(input int n, input logic [11:0] base, input logic [11:0] stride,
                           input int max_cyc, output int acc, output int first, output int last);
    int c = 0;
    acc = 0; first = -1; last = -1;
    bus.req_wr = 1'b0; bus.req_vld = 1'b1; bus.req_addr = base;
    while (acc < n && c < max_cyc) begin
      @(negedge clk);
      if (bus.req_rdy) begin
        if (first < 0) first = c;
        last = c;
        acc++;
      end
      @(posedge clk); #1;
      bus.req_addr = base + 12'(acc) * stride;
      c++;
    end
    bus.req_vld = 1'b0;
  endtask

  task automatic rd_expect(input string nm, input logic [11:0] a, input logic [143:0] exp);
    int lat, acc, f, l;
    run_reads(1, a, 12'd0, 20, acc, f, l);
    chk({nm, "_acc"}, 144'(acc), 144'(1));
    lat = 1;
    @(negedge clk);
    while (!bus.rsp_vld && lat < 10) begin
      lat++;
      @(negedge clk);
    end
    chk({nm, "_lat"},  144'(lat), 144'(2));
    chk({nm, "_data"}, bus.rsp_rdata, exp);
    @(posedge clk); #1;
  endtask

  task automatic wait_init(input string nm);
    int n = 0;
    @(negedge clk);
    while (!bus.init_done && n < 6000) begin
      n++;
      @(negedge clk);
    end
    chk(nm, 144'(n), 144'(INIT_CYC));
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, f, l, nvld;
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, f, l, nvld;
    for (int i = 0; i < 4096; i++) begin
      sram_mem[i] = pattern(i);
      exp_mem[i]  = pattern(i);
    end
    bus.req_vld = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_wmask = '0; bus.rsp_rdy = 1'b1;
    cpurst_b = 1'b1;
    #1 cpurst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 cpurst_b = 1'b1;
    wait_init("init_latency");

`ifdef CT_F_SPSRAM_INIT_CLR_EN
    rd_expect("clr_000", 12'h000, 144'(0));
    rd_expect("clr_abc", 12'hABC, 144'(0));
    rd_expect("clr_fff", 12'hFFF, 144'(0));
`endif

    wr(12'h123, ONES, ONES);
    rd_expect("wr_rd_123", 12'h123, ONES);

    wr(12'h010, 144'(0), ONES);
    wr(12'h010, ONES, 144'hFF);
    rd_expect("mask_010", 12'h010, 144'hFF);

    wr(12'h020, ONES, 144'(0));
`ifdef CT_F_SPSRAM_INIT_CLR_EN
    rd_expect("mask0_020", 12'h020, 144'(0));
`else
    rd_expect("mask0_020", 12'h020, pattern(32'h020));
`endif

    // Backpressure: two credits only, then drain in order.
    bus.rsp_rdy = 1'b0;
    run_reads(3, 12'h010, 12'h113, 6, acc, f, l);
    chk("bp_accepts", 144'(acc), 144'(2));
    @(negedge clk);
    chk("bp_req_rdy_low", 144'(bus.req_rdy), 144'(0));
    chk("bp_head_data",   bus.rsp_rdata,     144'hFF);
    @(posedge clk); #1;
    bus.rsp_rdy = 1'b1;
    run_reads(1, 12'h236, 12'd0, 10, acc, f, l);
    chk("bp_third_first", 144'(f), 144'(0));
    repeat (6) @(posedge clk);
    #1;

    run_reads(16, 12'h200, 12'd1, 40, acc, f, l);
    chk("stream_accepts", 144'(acc),   144'(16));
    chk("stream_span",    144'(l - f), 144'(15));
    repeat (6) @(posedge clk);
    #1;

    // Reset with a full FIFO and a blocked read.
    bus.rsp_rdy = 1'b0;
    run_reads(2, 12'h123, 12'd0, 6, acc, f, l);
    chk("full_accepts", 144'(acc), 144'(2));
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 12'h010;
    @(negedge clk);
    #2 cpurst_b = 1'b0;
    #1;
    chk("midrst_rsp_vld", 144'(bus.rsp_vld), 144'(0));
    chk("midrst_cen",     144'(sram_cen),    144'(1));
    chk("midrst_req_rdy", 144'(bus.req_rdy), 144'(0));
    bus.req_vld = 1'b0;
    bus.rsp_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 cpurst_b = 1'b1;
    nvld = 0;
    for (int i = 0; i < INIT_CYC + 6; i++) begin
      @(negedge clk);
      if (bus.rsp_vld) nvld++;
    end
    chk("post_rst_no_stale", 144'(nvld), 144'(0));
    @(posedge clk); #1;
`ifdef CT_F_SPSRAM_INIT_CLR_EN
    rd_expect("post_rst_123", 12'h123, 144'(0));
`else
    rd_expect("post_rst_123", 12'h123, ONES);
`endif
    repeat (4) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
